// File: rtl/storage_latch.sv
// Transparent-high D latch with asynchronous active-low clear, one per bit.
`timescale 1ns/1ps
module storage_latch #(
  parameter int WIDTH = 1
) (
  input  logic             en,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] lat_q;

  // Clear wins over enable; open while en is high, hold while low.
  always_latch begin
    if (!rst_n)  lat_q <= '0;
    else if (en) lat_q <= d;
  end

  assign q = lat_q;

endmodule

// File: rtl/compare_storage_elm.sv
// Side-by-side latch / posedge FF / negedge FF sharing one data input and clock.
`timescale 1ns/1ps
module compare_storage_elm #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_a,
  output logic [WIDTH-1:0] q_b,
  output logic [WIDTH-1:0] q_c
);

  logic [WIDTH-1:0] q_b_d, q_b_q;
  logic [WIDTH-1:0] q_c_d, q_c_q;

  // Level-sensitive element: transparent during the high phase of clk.
  storage_latch #(.WIDTH(WIDTH)) u_latch (
    .en    (clk),
    .rst_n (rst_n),
    .d     (d),
    .q     (q_a)
  );

  // Both flops capture the shared data input unchanged.
  always_comb begin
    q_b_d = d;
    q_c_d = d;
  end

  // Rising-edge sampler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_b_q <= '0;
    else        q_b_q <= q_b_d;
  end

  // Falling-edge sampler.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) q_c_q <= '0;
    else        q_c_q <= q_c_d;
  end

  assign q_b = q_b_q;
  assign q_c = q_c_q;

endmodule

// File: tb/tb_compare_storage_elm.sv
// Bench for compare_storage_elm: directed latch/edge scenarios followed by
// random data and reset pulses, checked every ns against a per-bit model.
`timescale 1ns/1ps
module tb_compare_storage_elm;
  localparam int W     = 4;
  localparam int T_END = 2200;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] d;
  logic [W-1:0] q_a, q_b, q_c;

  int n_chk  = 0;
  int n_pass = 0;

  compare_storage_elm #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .q_a   (q_a),
    .q_b   (q_b),
    .q_c   (q_c)
  );

  task automatic chk(input string tag, input int t, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%b exp=%b", tag, t, got, exp);
  endtask

  // Reference: latch copies d whenever enabled; each flop copies the value d
  // held just before its own edge; reset clears everything.
  logic [W-1:0] m_a, m_b, m_c;

  initial begin
    logic         clk_n, clk_prev;
    logic [W-1:0] d_n, d_prev;
    logic         r_n;
    m_a = '0; m_b = '0; m_c = '0;
    clk_prev = 1'b0;
    d_prev   = '0;
    d_n      = {W{1'b1}};
    r_n      = 1'b0;
    for (int t = 0; t < T_END; t++) begin
      clk_n = ((t % 20) >= 10);
      if (t < 120) begin
        // Directed phase; data never changes on a clock edge.
        case (t)
          5:  r_n = 1'b1;
          41: d_n = '0;            // after negedge 40
          51: d_n = {W{1'b1}};     // glitch train in the 50-60 high phase
          52: d_n = '0;
          55: d_n = {W{1'b1}};
          59: d_n = '0;
          71: d_n = {W{1'b1}};
          73: r_n = 1'b0;          // reset pulse mid high phase
          75: r_n = 1'b1;
          77: d_n = '0;
          81: d_n = {W{1'b1}};     // just after negedge 80
          95: d_n = 4'b1010;       // bits diverge from here on
          default: ;
        endcase
      end else if ((t % 10) != 0) begin
        if ($urandom_range(2) == 0) d_n = W'($urandom);
        if (r_n && $urandom_range(60) == 0)       r_n = 1'b0;
        else if (!r_n && $urandom_range(2) == 0)  r_n = 1'b1;
      end

      clk   = clk_n;
      d     = d_n;
      rst_n = r_n;

      for (int i = 0; i < W; i++) begin
        if (!r_n) begin
          m_a[i] = 1'b0; m_b[i] = 1'b0; m_c[i] = 1'b0;
        end else begin
          if (clk_n && !clk_prev) m_b[i] = d_prev[i];
          if (!clk_n && clk_prev) m_c[i] = d_prev[i];
          if (clk_n)              m_a[i] = d_n[i];
        end
      end
      clk_prev = clk_n;
      d_prev   = d_n;

      #0.5;
      chk("q_a_latch", t, q_a, m_a);
      chk("q_b_posff", t, q_b, m_b);
      chk("q_c_negff", t, q_c, m_c);

      // A few literal spot checks against hand-derived values.
      case (t)
        3:  chk("rst_all_zero", t, q_a | q_b | q_c, '0);
        10: chk("first_pos_qb", t, q_b, {W{1'b1}});
        20: chk("first_neg_qc", t, q_c, {W{1'b1}});
        45: chk("latch_holds",  t, q_a, {W{1'b1}});
        53: chk("glitch_low",   t, q_a, '0);
        56: chk("glitch_high",  t, q_a, {W{1'b1}});
        74: chk("rst_mid_high", t, q_a, '0);
        76: chk("rst_release",  t, q_a, {W{1'b1}});
        85: chk("qc_old_value", t, q_c, '0);
        90: chk("qb_at_90",     t, q_b, {W{1'b1}});
        100: chk("qc_at_100",   t, q_c, 4'b1010);
        default: ;
      endcase
      #0.5;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
